spi_frame_buffer: RTL and testbench

//  Parametrised frame buffer between the byte-level SPI receive and send units of the sensing pipeline.

---
 rtl/spi_frame_buffer_if.sv | 29 ++
 rtl/spi_frame_buffer.sv | 167 ++++++++++++++++
 tb/tb_spi_frame_buffer.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/spi_frame_buffer_if.sv
// Bus bundle between the SPI frame buffer and its receive/send units.
// The slave modport is the buffer's view; master is the environment's view.
interface spi_frame_buffer_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 64
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic              ssel_n;
  logic              rx_valid;
  logic [DATA_W-1:0] rx_data;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ack;
  logic [ADDR_W:0]   fill_level;
  logic              frame_full;
  logic              frame_sent;
  logic              overrun;

  modport master (
    output ssel_n, rx_valid, rx_data, tx_ack,
    input  tx_data, tx_valid, fill_level, frame_full, frame_sent, overrun
  );

  modport slave (
    input  ssel_n, rx_valid, rx_data, tx_ack,
    output tx_data, tx_valid, fill_level, frame_full, frame_sent, overrun
  );
endinterface

// File: rtl/spi_frame_buffer.sv
// Frame buffer: collects DEPTH SPI words, then drains them in order under valid/ack.
// Optional trailing checksum word enabled by defining SPI_FB_CHECKSUM_EN.
module spi_frame_buffer #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 64
) (
  input logic               clk,
  input logic               rst_n,
  spi_frame_buffer_if.slave bus
);
  localparam int ADDR_W = $clog2(DEPTH);

  localparam logic [1:0] FILL  = 2'd0;
  localparam logic [1:0] DRAIN = 2'd1;
`ifdef SPI_FB_CHECKSUM_EN
  localparam logic [1:0] CSUM  = 2'd2;
`endif

  localparam logic [ADDR_W-1:0] LAST_PTR   = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] PTR_ONE    = ADDR_W'(1);
  localparam logic [ADDR_W:0]   LEVEL_ONE  = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W:0]   LEVEL_FULL = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] wrPtr_q, wrPtr_d;
  logic [ADDR_W-1:0] rdPtr_q, rdPtr_d;
  logic [ADDR_W:0]   fillLevel_q, fillLevel_d;
  logic [DATA_W-1:0] txData_q, txData_d;
  logic              frameSent_q, frameSent_d;
  logic              overrun_q, overrun_d;
  logic              memWe;
  logic [ADDR_W-1:0] rdNext;
`ifdef SPI_FB_CHECKSUM_EN
  logic [DATA_W-1:0] csum_q, csum_d;
`endif

  assign rdNext = rdPtr_q + PTR_ONE;

  always_comb begin
    state_d     = state_q;
    wrPtr_d     = wrPtr_q;
    rdPtr_d     = rdPtr_q;
    fillLevel_d = fillLevel_q;
    txData_d    = txData_q;
    frameSent_d = 1'b0;
    overrun_d   = overrun_q;
    memWe       = 1'b0;
`ifdef SPI_FB_CHECKSUM_EN
    csum_d      = csum_q;
`endif

    case (state_q)
      FILL: begin
        // Deselect always wins over a coincident word; the partial frame is thrown away.
        if (bus.ssel_n) begin
          wrPtr_d     = '0;
          fillLevel_d = '0;
`ifdef SPI_FB_CHECKSUM_EN
          csum_d      = '0;
`endif
        end else if (bus.rx_valid) begin
          memWe       = 1'b1;
          fillLevel_d = fillLevel_q + LEVEL_ONE;
`ifdef SPI_FB_CHECKSUM_EN
          csum_d      = csum_q + bus.rx_data;
`endif
          if (wrPtr_q == '0) begin
            overrun_d = 1'b0;
          end
          if (wrPtr_q == LAST_PTR) begin
            state_d  = DRAIN;
            txData_d = mem_q[0];
          end else begin
            wrPtr_d = wrPtr_q + PTR_ONE;
          end
        end
      end

      DRAIN: begin
        if (bus.rx_valid) begin
          overrun_d = 1'b1;
        end
        if (bus.tx_ack) begin
          if (rdPtr_q == LAST_PTR) begin
`ifdef SPI_FB_CHECKSUM_EN
            state_d  = CSUM;
            txData_d = csum_q;
`else
            state_d     = FILL;
            frameSent_d = 1'b1;
            fillLevel_d = '0;
            rdPtr_d     = '0;
            wrPtr_d     = '0;
            txData_d    = '0;
`endif
          end else begin
            rdPtr_d  = rdNext;
            txData_d = mem_q[rdNext];
          end
        end
      end

`ifdef SPI_FB_CHECKSUM_EN
      CSUM: begin
        if (bus.rx_valid) begin
          overrun_d = 1'b1;
        end
        if (bus.tx_ack) begin
          state_d     = FILL;
          frameSent_d = 1'b1;
          fillLevel_d = '0;
          rdPtr_d     = '0;
          wrPtr_d     = '0;
          txData_d    = '0;
          csum_d      = '0;
        end
      end
`endif

      default: begin
        state_d = FILL;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FILL;
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      fillLevel_q <= '0;
      txData_q    <= '0;
      frameSent_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef SPI_FB_CHECKSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      wrPtr_q     <= wrPtr_d;
      rdPtr_q     <= rdPtr_d;
      fillLevel_q <= fillLevel_d;
      txData_q    <= txData_d;
      frameSent_q <= frameSent_d;
      overrun_q   <= overrun_d;
`ifdef SPI_FB_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  // Storage is deliberately left out of reset; stale words are never offered.
  always_ff @(posedge clk) begin
    if (memWe) begin
      mem_q[wrPtr_q] <= bus.rx_data;
    end
  end

  assign bus.tx_data    = txData_q;
  assign bus.tx_valid   = (state_q != FILL);
  assign bus.frame_full = (state_q != FILL);
  assign bus.fill_level = fillLevel_q;
  assign bus.frame_sent = frameSent_q;
  assign bus.overrun    = overrun_q;
endmodule

// File: tb/tb_spi_frame_buffer.sv
// Directed self-checking bench for spi_frame_buffer (DATA_W=8, DEPTH=64).
// Expects the checksum word only when SPI_FB_CHECKSUM_EN is defined.
module tb_spi_frame_buffer;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 64;

  logic clk;
  logic rst_n;
  int   checkCount = 0;
  int   failCount  = 0;

  spi_frame_buffer_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  spi_frame_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One clock with the given inputs; rx_valid and tx_ack are single-cycle pulses.
  task automatic applyStimulus(input logic rxValid, input logic [7:0] rxData,
                               input logic sselN, input logic txAck);
    bus.rx_valid = rxValid;
    bus.rx_data  = rxData;
    bus.ssel_n   = sselN;
    bus.tx_ack   = txAck;
    tick();
    bus.rx_valid = 1'b0;
    bus.tx_ack   = 1'b0;
  endtask

  task automatic fillWords(input logic [7:0] base, input int count);
    for (int i = 0; i < count; i++) begin
      applyStimulus(1'b1, base + 8'(i), 1'b0, 1'b0);
    end
  endtask

  task automatic drainFrame(input logic [7:0] base, input bit inject);
    logic [7:0] sum;
    logic [7:0] word;
    sum = 8'h00;
    for (int i = 0; i < DEPTH; i++) begin
      word = base + 8'(i);
      sum  = sum + word;
      checkOutput("txValid", 32'(bus.tx_valid), 32'd1);
      checkOutput("txData", 32'(bus.tx_data), 32'(word));
      if (inject && i == 5) begin
        applyStimulus(1'b1, 8'hFF, 1'b0, 1'b0);
        checkOutput("overrunSet", 32'(bus.overrun), 32'd1);
        checkOutput("txDataAfterDrop", 32'(bus.tx_data), 32'(word));
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("fillAfterSselDrain", 32'(bus.fill_level), 32'd64);
        checkOutput("fullAfterSselDrain", 32'(bus.frame_full), 32'd1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      end
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
      if (i < DEPTH - 1) begin
        checkOutput("frameSentEarly", 32'(bus.frame_sent), 32'd0);
        tick();
        tick();
      end
    end
`ifdef SPI_FB_CHECKSUM_EN
    checkOutput("csumFrameSent", 32'(bus.frame_sent), 32'd0);
    checkOutput("csumTxValid", 32'(bus.tx_valid), 32'd1);
    checkOutput("csumFull", 32'(bus.frame_full), 32'd1);
    checkOutput("csumTxData", 32'(bus.tx_data), 32'(sum));
    tick();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
`endif
    checkOutput("frameSent", 32'(bus.frame_sent), 32'd1);
    checkOutput("txValidEnd", 32'(bus.tx_valid), 32'd0);
    checkOutput("fullEnd", 32'(bus.frame_full), 32'd0);
    checkOutput("fillEnd", 32'(bus.fill_level), 32'd0);
    tick();
    checkOutput("frameSentPulse", 32'(bus.frame_sent), 32'd0);
  endtask

  initial begin
    rst_n        = 1'b0;
    bus.ssel_n   = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    bus.tx_ack   = 1'b0;
    #12;
    checkOutput("rstTxData", 32'(bus.tx_data), 32'd0);
    checkOutput("rstTxValid", 32'(bus.tx_valid), 32'd0);
    checkOutput("rstFill", 32'(bus.fill_level), 32'd0);
    checkOutput("rstFull", 32'(bus.frame_full), 32'd0);
    checkOutput("rstSent", 32'(bus.frame_sent), 32'd0);
    checkOutput("rstOverrun", 32'(bus.overrun), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("[TB] Reset mid-fill");
    fillWords(8'h10, 20);
    checkOutput("fill20", 32'(bus.fill_level), 32'd20);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midRstFill", 32'(bus.fill_level), 32'd0);
    checkOutput("midRstTxValid", 32'(bus.tx_valid), 32'd0);
    checkOutput("midRstFull", 32'(bus.frame_full), 32'd0);
    checkOutput("midRstTxData", 32'(bus.tx_data), 32'd0);
    checkOutput("midRstSent", 32'(bus.frame_sent), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("[TB] Full frame 0x00..0x3F");
    fillWords(8'h00, 63);
    checkOutput("fill63", 32'(bus.fill_level), 32'd63);
    checkOutput("full63", 32'(bus.frame_full), 32'd0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("ackInFillIgnored", 32'(bus.fill_level), 32'd63);
    fillWords(8'h3F, 1);
    checkOutput("fill64", 32'(bus.fill_level), 32'd64);
    checkOutput("full64", 32'(bus.frame_full), 32'd1);
    checkOutput("txValid64", 32'(bus.tx_valid), 32'd1);
    checkOutput("txData64", 32'(bus.tx_data), 32'd0);
    drainFrame(8'h00, 1'b0);

    $display("[TB] Abort on deselect");
    fillWords(8'h55, 10);
    checkOutput("fill10", 32'(bus.fill_level), 32'd10);
    applyStimulus(1'b1, 8'h99, 1'b1, 1'b0);
    checkOutput("abortFill", 32'(bus.fill_level), 32'd0);
    checkOutput("abortNoOverrun", 32'(bus.overrun), 32'd0);
    fillWords(8'hA0, DEPTH);
    checkOutput("fillA0", 32'(bus.fill_level), 32'd64);
    drainFrame(8'hA0, 1'b0);

    $display("[TB] Overrun during drain, frame 0x01..0x40");
    fillWords(8'h01, DEPTH);
    drainFrame(8'h01, 1'b1);
    checkOutput("overrunSticky", 32'(bus.overrun), 32'd1);
    fillWords(8'h33, 1);
    checkOutput("overrunCleared", 32'(bus.overrun), 32'd0);
    checkOutput("fillNext", 32'(bus.fill_level), 32'd1);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("abortFinal", 32'(bus.fill_level), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end
endmodule
